// File: rtl/mario_sprite_pkg.sv
// Shared types and defaults for the Mario sprite fetch path.
// anim_state_t values double as the sprite ROM frame select.
package mario_sprite_pkg;

    typedef enum logic [2:0] {
        STAND = 3'd0,
        WALK1 = 3'd1,
        WALK2 = 3'd2,
        WALK3 = 3'd3,
        JUMP  = 3'd4
    } anim_state_t;

    localparam int          SPRITE_W_DEF  = 21;
    localparam int          SPRITE_H_DEF  = 21;
    localparam int          ANIM_DIV_DEF  = 6;
    localparam logic [23:0] KEY_COLOR_DEF = 24'h800080;

    // Walk cycle order; non-walk states restart the cycle.
    function automatic anim_state_t next_walk(input anim_state_t s);
        case (s)
            WALK1:   return WALK2;
            WALK2:   return WALK3;
            default: return WALK1;
        endcase
    endfunction

endpackage

// File: rtl/mario_anim_fsm.sv
// Walk/jump animation state, advanced only on rising edges of the vsync-rate frame_clk.
// state_o is both the live frame select and the debug view of the FSM.
module mario_anim_fsm
    import mario_sprite_pkg::*;
#(
    parameter int ANIM_DIV = ANIM_DIV_DEF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        frame_clk_i,
    input  logic        walking_i,
    input  logic        airborne_i,
    output anim_state_t state_o
);

    localparam int            CW      = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(ANIM_DIV - 1);

    anim_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fc_q;
    logic          tick;

    // Edge register resets high so a frame_clk already high at release is not a tick.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= STAND;
            cnt_q   <= '0;
            fc_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fc_q    <= frame_clk_i;
        end
    end

    always_comb begin
        tick    = frame_clk_i & ~fc_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        if (tick) begin
            if (airborne_i) begin
                state_d = JUMP;
                cnt_d   = '0;
            end else if (!walking_i) begin
                state_d = STAND;
                cnt_d   = '0;
            end else if (state_q == STAND || state_q == JUMP) begin
                state_d = WALK1;
                cnt_d   = '0;
            end else if (cnt_q == CNT_MAX) begin
                state_d = next_walk(state_q);
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/mario_sprite_fetch.sv
// Two-stage sprite fetch: stage 1 forms the ROM address/frame from scan position,
// stage 2 applies the colour key to the combinational ROM data.
module mario_sprite_fetch
    import mario_sprite_pkg::*;
#(
    parameter int          SPRITE_W  = SPRITE_W_DEF,
    parameter int          SPRITE_H  = SPRITE_H_DEF,
    parameter int          ANIM_DIV  = ANIM_DIV_DEF,
    parameter logic [23:0] KEY_COLOR = KEY_COLOR_DEF
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_clk,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [9:0]  mario_x,
    input  logic [9:0]  mario_y,
    input  logic        facing_left,
    input  logic        walking,
    input  logic        airborne,
    output logic [8:0]  rom_addr,
    output logic [2:0]  rom_frame,
    input  logic [23:0] rom_color,
    output logic        sprite_on,
    output logic [23:0] sprite_color
);

    anim_state_t anim_state;

    mario_anim_fsm #(.ANIM_DIV(ANIM_DIV)) u_anim (
        .clk_i       (Clk),
        .rst_ni      (Reset_n),
        .frame_clk_i (frame_clk),
        .walking_i   (walking),
        .airborne_i  (airborne),
        .state_o     (anim_state)
    );

    logic signed [10:0] dx, dy;
    logic               in_box_d, in_box_q;
    logic [8:0]         col;
    logic [8:0]         rom_addr_d, rom_addr_q;
    logic [2:0]         rom_frame_q;
    logic               sprite_on_d, sprite_on_q;
    logic [23:0]        sprite_color_d, sprite_color_q;

    // Offsets are signed so sprites hanging off either screen edge never wrap into the box.
    always_comb begin
        dx         = $signed({1'b0, DrawX}) - $signed({1'b0, mario_x});
        dy         = $signed({1'b0, DrawY}) - $signed({1'b0, mario_y});
        in_box_d   = !dx[10] && (dx[9:0] < 10'(SPRITE_W)) &&
                     !dy[10] && (dy[9:0] < 10'(SPRITE_H));
        col        = facing_left ? (9'(SPRITE_W - 1) - dx[8:0]) : dx[8:0];
        rom_addr_d = in_box_d ? (9'(dy[8:0] * 9'(SPRITE_W)) + col) : '0;
    end

    always_comb begin
        sprite_on_d    = in_box_q && (rom_color != KEY_COLOR);
        sprite_color_d = sprite_on_d ? rom_color : '0;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            rom_addr_q     <= '0;
            rom_frame_q    <= '0;
            in_box_q       <= 1'b0;
            sprite_on_q    <= 1'b0;
            sprite_color_q <= '0;
        end else begin
            rom_addr_q     <= rom_addr_d;
            rom_frame_q    <= 3'(anim_state);
            in_box_q       <= in_box_d;
            sprite_on_q    <= sprite_on_d;
            sprite_color_q <= sprite_color_d;
        end
    end

    assign rom_addr     = rom_addr_q;
    assign rom_frame    = rom_frame_q;
    assign sprite_on    = sprite_on_q;
    assign sprite_color = sprite_color_q;

endmodule

// File: tb/tb_mario_sprite_fetch.sv
// Bench for mario_sprite_fetch: a behavioural ROM, a pixel/animation reference model,
// directed scenarios and a randomized run.
module tb_mario_sprite_fetch;

    localparam int          SW  = 21;
    localparam int          SH  = 21;
    localparam int          DIV = 6;
    localparam logic [23:0] KEY = 24'h800080;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        frame_clk;
    logic [9:0]  DrawX, DrawY, mario_x, mario_y;
    logic        facing_left, walking, airborne;
    logic [8:0]  rom_addr;
    logic [2:0]  rom_frame;
    logic [23:0] rom_color;
    logic        sprite_on;
    logic [23:0] sprite_color;

    logic        rom_force;
    logic [23:0] rom_force_val;

    int errors = 0;
    int checks = 0;

    // {in_box, addr[8:0], frame[2:0]} per pixel accepted by stage 1
    logic [12:0] exp_q[$];
    int          m_state, m_cnt;
    bit          m_fc;

    always #5 Clk = ~Clk;

    mario_sprite_fetch #(
        .SPRITE_W(SW), .SPRITE_H(SH), .ANIM_DIV(DIV), .KEY_COLOR(KEY)
    ) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .frame_clk    (frame_clk),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .mario_x      (mario_x),
        .mario_y      (mario_y),
        .facing_left  (facing_left),
        .walking      (walking),
        .airborne     (airborne),
        .rom_addr     (rom_addr),
        .rom_frame    (rom_frame),
        .rom_color    (rom_color),
        .sprite_on    (sprite_on),
        .sprite_color (sprite_color)
    );

    function automatic logic [23:0] rom_fn(input logic [8:0] a, input logic [2:0] f);
        int s;
        s = int'(a) + int'(f);
        if (s % 4 == 0) return KEY;
        return {f, 3'b101, a, 9'(s * 7)};
    endfunction

    always_comb rom_color = rom_force ? rom_force_val : rom_fn(rom_addr, rom_frame);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [12:0] pixel_model();
        int dx, dy, col, addr;
        bit inb;
        dx   = int'(DrawX) - int'(mario_x);
        dy   = int'(DrawY) - int'(mario_y);
        inb  = (dx >= 0) && (dx < SW) && (dy >= 0) && (dy < SH);
        col  = facing_left ? (SW - 1 - dx) : dx;
        addr = inb ? (dy * SW + col) : 0;
        return {inb, 9'(addr), 3'(m_state)};
    endfunction

    task automatic anim_model();
        bit tick;
        tick = frame_clk && !m_fc;
        m_fc = frame_clk;
        if (tick) begin
            if (airborne) begin
                m_state = 4; m_cnt = 0;
            end else if (!walking) begin
                m_state = 0; m_cnt = 0;
            end else if (m_state == 0 || m_state == 4) begin
                m_state = 1; m_cnt = 0;
            end else if (m_cnt == DIV - 1) begin
                m_state = (m_state % 3) + 1; m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
    endtask

    // One clock: model the edge, then check both pipeline stages on the falling edge.
    task automatic step();
        logic [12:0] e, prev;
        logic [23:0] c;
        logic        exp_on;
        bit          rst_now;
        @(posedge Clk);
        rst_now = !Reset_n;
        if (rst_now) begin
            e = '0; m_state = 0; m_cnt = 0; m_fc = 1'b1;
        end else begin
            e = pixel_model();
            anim_model();
        end
        exp_q.push_back(e);
        @(negedge Clk);
        check("rom_addr", 32'(rom_addr), 32'(e[11:3]));
        check("rom_frame", 32'(rom_frame), 32'(e[2:0]));
        if (rst_now) begin
            check("sprite_on_rst", 32'(sprite_on), 32'd0);
            check("sprite_color_rst", 32'(sprite_color), 32'd0);
        end else if (exp_q.size() >= 2) begin
            prev   = exp_q[exp_q.size() - 2];
            c      = rom_force ? rom_force_val : rom_fn(prev[11:3], prev[2:0]);
            exp_on = prev[12] && (c != KEY);
            check("sprite_on", 32'(sprite_on), 32'(exp_on));
            check("sprite_color", 32'(sprite_color), exp_on ? 32'(c) : 32'd0);
        end
        while (exp_q.size() > 2) void'(exp_q.pop_front());
    endtask

    task automatic frame_pulse();
        frame_clk = 1'b1; step();
        frame_clk = 1'b0; step(); step();
    endtask

    initial begin
        int pulse_exp[4];
        int pulse_at[4];
        Reset_n = 1'b0; frame_clk = 1'b1;
        DrawX = '0; DrawY = '0; mario_x = 10'd100; mario_y = 10'd50;
        facing_left = 1'b0; walking = 1'b1; airborne = 1'b0;
        rom_force = 1'b0; rom_force_val = '0;
        m_state = 0; m_cnt = 0; m_fc = 1'b1;

        // Reset with frame_clk high, then release with it still high: no tick.
        step(); step();
        Reset_n = 1'b1;
        repeat (4) step();
        check("no_tick_after_reset", 32'(rom_frame), 32'd0);

        // Address map
        frame_clk = 1'b0;
        DrawX = 10'd105; DrawY = 10'd53; step();
        check("addr_right", 32'(rom_addr), 32'd68);
        facing_left = 1'b1; step();
        check("addr_left", 32'(rom_addr), 32'd78);
        facing_left = 1'b0; DrawX = 10'd121; step();
        check("addr_outside", 32'(rom_addr), 32'd0);
        step(); step();
        check("outside_sprite_off", 32'(sprite_on), 32'd0);

        // Transparency and two-cycle latency
        rom_force = 1'b1; rom_force_val = KEY;
        DrawX = 10'd105; step(); step(); step();
        check("key_transparent", 32'(sprite_on), 32'd0);
        rom_force_val = 24'hF83800;
        DrawX = 10'd121; step(); step();
        DrawX = 10'd106; step();
        check("latency_1cyc", 32'(sprite_on), 32'd0);
        DrawX = 10'd121; step();
        check("latency_2cyc_on", 32'(sprite_on), 32'd1);
        check("latency_2cyc_color", 32'(sprite_color), 32'hF83800);
        rom_force = 1'b0;

        // Walk cycle over 19 pulses
        walking = 1'b0; frame_pulse();
        walking = 1'b1;
        pulse_at  = '{1, 7, 13, 19};
        pulse_exp = '{1, 2, 3, 1};
        for (int p = 1; p <= 19; p++) begin
            frame_pulse();
            for (int k = 0; k < 4; k++)
                if (pulse_at[k] == p) check($sformatf("walk_p%0d", p), 32'(rom_frame), 32'(pulse_exp[k]));
        end

        // Priority
        airborne = 1'b1; frame_pulse();
        check("prio_jump", 32'(rom_frame), 32'd4);
        airborne = 1'b0; frame_pulse();
        check("prio_walk1", 32'(rom_frame), 32'd1);
        walking = 1'b0; frame_pulse();
        check("prio_stand", 32'(rom_frame), 32'd0);

        // Screen-edge cases
        mario_x = 10'd630; mario_y = 10'd50; DrawY = 10'd52;
        DrawX = 10'd639; step();
        check("edge_639", 32'(rom_addr), 32'd51);
        DrawX = 10'd640; step();
        check("edge_640", 32'(rom_addr), 32'd52);
        mario_x = 10'd0; DrawX = 10'd0; step();
        check("edge_x0", 32'(rom_addr), 32'd42);
        mario_x = 10'd10; DrawX = 10'd5; step();
        check("left_of_sprite", 32'(rom_addr), 32'd0);
        mario_x = 10'd1015; DrawX = 10'd3; step();
        check("no_wrap", 32'(rom_addr), 32'd0);

        // Reset mid-stream while opaque
        rom_force = 1'b1; rom_force_val = 24'hF83800;
        mario_x = 10'd100; DrawX = 10'd110; step(); step(); step();
        check("pre_reset_on", 32'(sprite_on), 32'd1);
        Reset_n = 1'b0; step();
        check("reset_clears_on", 32'(sprite_on), 32'd0);
        Reset_n = 1'b1; rom_force = 1'b0; step();

        // Randomized stream
        for (int i = 0; i < 3000; i++) begin
            Reset_n = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 2) == 0) frame_clk = ~frame_clk;
            if ($urandom_range(0, 39) == 0) walking = $urandom_range(0, 1);
            if ($urandom_range(0, 59) == 0) airborne = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 49) == 0) begin
                mario_x = 10'($urandom_range(0, 1023));
                mario_y = 10'($urandom_range(0, 1023));
                facing_left = $urandom_range(0, 1);
            end
            DrawX = mario_x + 10'($urandom_range(0, 30)) - 10'd5;
            DrawY = mario_y + 10'($urandom_range(0, 30)) - 10'd5;
            rom_force = ($urandom_range(0, 19) == 0);
            rom_force_val = ($urandom_range(0, 1) != 0) ? KEY : 24'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
